// File: rtl/decode_pkg.sv
// Shared decode-stage types: RV32I opcodes, immediate/ALU codes and the decode packet.
package decode_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_J    = 3'b011,
      IMM_U    = 3'b100,
      IMM_NONE = 3'b111
   } imm_type_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic reg_we;
      logic mem_re;
      logic mem_we;
      logic branch;
      logic jump;
      logic alu_src_imm;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [24:0]         imm_val;
      imm_type_e           imm_type;
      alu_op_e             alu_op;
      ctrl_t               ctrl;
      logic                illegal;
   } decode_pkt_t;

   // alt selects SUB/SRA; callers decide when instr[30] is meaningful
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered upstream ready; SKID_EN=0 degrades to a single
// pipeline register with combinational ready.
module pipe_skid_buf #(
   parameter type T       = logic [7:0],
   parameter bit  SKID_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic up_valid,
   output logic up_ready,
   input  T     up_data,
   output logic dn_valid,
   input  logic dn_ready,
   output T     dn_data
);

   generate
      if (SKID_EN) begin : g_skid
         localparam logic [1:0] ST_EMPTY = 2'd0;
         localparam logic [1:0] ST_ONE   = 2'd1;
         localparam logic [1:0] ST_TWO   = 2'd2;

         logic [1:0] state_reg, state_next;
         T           out_reg, out_next;
         T           skid_reg, skid_next;
         logic       ready_reg;
         logic       up_fire, dn_fire;

         assign up_fire  = up_valid & ready_reg;
         assign dn_fire  = dn_ready & (state_reg != ST_EMPTY);
         assign up_ready = ready_reg;
         assign dn_valid = (state_reg != ST_EMPTY);
         assign dn_data  = out_reg;

         always_comb begin
            state_next = state_reg;
            out_next   = out_reg;
            skid_next  = skid_reg;
            case (state_reg)
               ST_EMPTY: if (up_fire) begin
                  state_next = ST_ONE;
                  out_next   = up_data;
               end
               ST_ONE: begin
                  if (up_fire && !dn_fire) begin
                     state_next = ST_TWO;
                     skid_next  = up_data;
                  end else if (up_fire && dn_fire) begin
                     out_next = up_data;
                  end else if (dn_fire) begin
                     state_next = ST_EMPTY;
                  end
               end
               ST_TWO: if (dn_fire) begin
                  state_next = ST_ONE;
                  out_next   = skid_reg;
               end
               default: state_next = ST_EMPTY;
            endcase
            // a redirect drops everything held plus whatever IF offered this cycle
            if (flush) state_next = ST_EMPTY;
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state_reg <= ST_EMPTY;
               out_reg   <= '0;
               skid_reg  <= '0;
               ready_reg <= 1'b0;
            end else begin
               state_reg <= state_next;
               out_reg   <= out_next;
               skid_reg  <= skid_next;
               ready_reg <= (state_next != ST_TWO);
            end
         end
      end else begin : g_single
         logic valid_reg;
         T     data_reg;

         assign up_ready = dn_ready | ~valid_reg;
         assign dn_valid = valid_reg;
         assign dn_data  = data_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else if (flush) begin
               valid_reg <= 1'b0;
            end else if (up_ready) begin
               valid_reg <= up_valid;
               if (up_valid) data_reg <= up_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode front end: combinational field/control decode of the fetched word,
// captured into a skid buffer that drives the execute boundary.
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [2:0]      id_funct3,
   output logic [24:0]     id_imm_val,
   output logic [2:0]      id_imm_type,
   output logic [3:0]      id_alu_op,
   output logic [5:0]      id_ctrl,
   output logic            id_illegal
);

   decode_pkt_t dec;
   decode_pkt_t pkt;
   logic [6:0]  opcode;

   assign opcode = if_instr[6:0];

   always_comb begin
      dec          = '0;
      dec.pc       = if_pc;
      dec.rd       = if_instr[11:7];
      dec.rs1      = if_instr[19:15];
      dec.rs2      = if_instr[24:20];
      dec.funct3   = if_instr[14:12];
      dec.imm_val  = if_instr[31:7];
      dec.imm_type = IMM_NONE;
      dec.alu_op   = ALU_ADD;
      case (opcode)
         OPC_LUI: begin
            dec.imm_type    = IMM_U;
            dec.ctrl.reg_we = 1'b1;
            dec.alu_op      = ALU_PASS;
         end
         OPC_AUIPC: begin
            dec.imm_type    = IMM_U;
            dec.ctrl.reg_we = 1'b1;
         end
         OPC_JAL: begin
            dec.imm_type    = IMM_J;
            dec.ctrl.reg_we = 1'b1;
            dec.ctrl.jump   = 1'b1;
         end
         OPC_JALR: begin
            dec.imm_type    = IMM_I;
            dec.ctrl.reg_we = 1'b1;
            dec.ctrl.jump   = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm_type    = IMM_B;
            dec.ctrl.branch = 1'b1;
            dec.alu_op      = ALU_SUB;
         end
         OPC_LOAD: begin
            dec.imm_type    = IMM_I;
            dec.ctrl.reg_we = 1'b1;
            dec.ctrl.mem_re = 1'b1;
         end
         OPC_STORE: begin
            dec.imm_type    = IMM_S;
            dec.ctrl.mem_we = 1'b1;
         end
         OPC_OPIMM: begin
            // instr[30] is part of the immediate except on the shift-right encoding
            dec.imm_type         = IMM_I;
            dec.ctrl.reg_we      = 1'b1;
            dec.ctrl.alu_src_imm = 1'b1;
            dec.alu_op = alu_from_funct3(if_instr[14:12],
                                         (if_instr[14:12] == 3'b101) & if_instr[30]);
         end
         OPC_OP: begin
            dec.ctrl.reg_we = 1'b1;
            dec.alu_op      = alu_from_funct3(if_instr[14:12], if_instr[30]);
         end
         OPC_FENCE: ;
         default: dec.illegal = 1'b1;
      endcase
      if (dec.rd == 5'd0) dec.ctrl.reg_we = 1'b0;
   end

   pipe_skid_buf #(
      .T       (decode_pkt_t),
      .SKID_EN (SKID_EN)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (if_valid),
      .up_ready (if_ready),
      .up_data  (dec),
      .dn_valid (id_valid),
      .dn_ready (id_ready),
      .dn_data  (pkt)
   );

   assign id_pc       = pkt.pc;
   assign id_rd       = pkt.rd;
   assign id_rs1      = pkt.rs1;
   assign id_rs2      = pkt.rs2;
   assign id_funct3   = pkt.funct3;
   assign id_imm_val  = pkt.imm_val;
   assign id_imm_type = pkt.imm_type;
   assign id_alu_op   = pkt.alu_op;
   assign id_ctrl     = pkt.ctrl;
   assign id_illegal  = pkt.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: hand-written expected decode per instruction,
// queued on acceptance and compared when the packet leaves the stage.
module tb_instr_decode_stage;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [2:0]  id_funct3;
   logic [24:0] id_imm_val;
   logic [2:0]  id_imm_type;
   logic [3:0]  id_alu_op;
   logic [5:0]  id_ctrl;
   logic        id_illegal;

   instr_decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_rd       (id_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_funct3   (id_funct3),
      .id_imm_val  (id_imm_val),
      .id_imm_type (id_imm_type),
      .id_alu_op   (id_alu_op),
      .id_ctrl     (id_ctrl),
      .id_illegal  (id_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  ityp;
      logic [5:0]  ctrl;
      logic [3:0]  alu;
      logic        alu_chk;
      logic        ill;
   } tbl_t;

   typedef struct {
      logic [31:0] pc;
      int          idx;
   } sb_t;

   tbl_t        tbl [13];
   sb_t         sb [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cur_idx  = 0;
   logic [31:0] pc_ctr   = 32'h0000_1000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // monitor: pop/compare on output transfer, push on input acceptance
   logic        stall_prev = 1'b0;
   logic [31:0] held_pc;
   logic [24:0] held_imm;
   logic [5:0]  held_ctrl;

   always @(negedge clk) begin
      if (stall_prev && id_valid) begin
         check("hold_pc", id_pc, held_pc);
         check("hold_imm", {7'd0, id_imm_val}, {7'd0, held_imm});
         check("hold_ctrl", {26'd0, id_ctrl}, {26'd0, held_ctrl});
      end
      stall_prev = id_valid && !id_ready && rst_n && !flush;
      held_pc    = id_pc;
      held_imm   = id_imm_val;
      held_ctrl  = id_ctrl;

      if (id_valid && id_ready) begin
         check("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            sb_t         e;
            tbl_t        t;
            logic [31:0] ins;
            e   = sb.pop_front();
            t   = tbl[e.idx];
            ins = t.instr;
            $display("out pc=%h instr=%h rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h type=%0d alu=%0d ctrl=%b ill=%b",
                     id_pc, ins, id_rd, id_rs1, id_rs2, id_funct3, id_imm_val, id_imm_type,
                     id_alu_op, id_ctrl, id_illegal);
            check("pc", id_pc, e.pc);
            check("rd", {27'd0, id_rd}, {27'd0, ins[11:7]});
            check("rs1", {27'd0, id_rs1}, {27'd0, ins[19:15]});
            check("rs2", {27'd0, id_rs2}, {27'd0, ins[24:20]});
            check("funct3", {29'd0, id_funct3}, {29'd0, ins[14:12]});
            check("imm_val", {7'd0, id_imm_val}, {7'd0, ins[31:7]});
            check("imm_type", {29'd0, id_imm_type}, {29'd0, t.ityp});
            check("ctrl", {26'd0, id_ctrl}, {26'd0, t.ctrl});
            check("illegal", {31'd0, id_illegal}, {31'd0, t.ill});
            if (t.alu_chk) check("alu_op", {28'd0, id_alu_op}, {28'd0, t.alu});
         end
      end

      if (!rst_n || flush) sb.delete();
      else if (if_valid && if_ready) sb.push_back('{pc: if_pc, idx: cur_idx});
   end

   task automatic send(input int idx);
      logic acc;
      int   n;
      acc      = 1'b0;
      n        = 0;
      if_valid = 1'b1;
      if_instr = tbl[idx].instr;
      if_pc    = pc_ctr;
      cur_idx  = idx;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = if_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("send_accept", {31'd0, acc}, 32'd1);
      if_valid = 1'b0;
      pc_ctr   = pc_ctr + 32'd4;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'h00500093, 3'b000, 6'b100001, ALU_ADD, 1'b1, 1'b0}; // addi x1,x0,5
      tbl[1]  = '{32'h0020A423, 3'b001, 6'b001000, ALU_ADD, 1'b1, 1'b0}; // sw x2,8(x1)
      tbl[2]  = '{32'h0000007F, 3'b111, 6'b000000, ALU_ADD, 1'b0, 1'b1}; // illegal
      tbl[3]  = '{32'h00000013, 3'b000, 6'b000001, ALU_ADD, 1'b1, 1'b0}; // addi x0,x0,0
      tbl[4]  = '{32'h40208133, 3'b111, 6'b100000, ALU_SUB, 1'b1, 1'b0}; // sub x2,x1,x2
      tbl[5]  = '{32'h123452B7, 3'b100, 6'b100000, ALU_ADD, 1'b0, 1'b0}; // lui x5
      tbl[6]  = '{32'h008000EF, 3'b011, 6'b100010, ALU_ADD, 1'b1, 1'b0}; // jal x1,8
      tbl[7]  = '{32'h00208463, 3'b010, 6'b000100, ALU_ADD, 1'b0, 1'b0}; // beq x1,x2,8
      tbl[8]  = '{32'h0040A183, 3'b000, 6'b110000, ALU_ADD, 1'b1, 1'b0}; // lw x3,4(x1)
      tbl[9]  = '{32'h0000000F, 3'b111, 6'b000000, ALU_ADD, 1'b0, 1'b0}; // fence
      tbl[10] = '{32'h4030D093, 3'b000, 6'b100001, ALU_SRA, 1'b1, 1'b0}; // srai x1,x1,3
      tbl[11] = '{32'h00001217, 3'b100, 6'b100000, ALU_ADD, 1'b1, 1'b0}; // auipc x4,1
      tbl[12] = '{32'h00008067, 3'b000, 6'b000010, ALU_ADD, 1'b1, 1'b0}; // jalr x0,0(x1)

      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'd0;
      if_pc    = 32'd0;
      flush    = 1'b0;
      id_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("rst_if_ready", {31'd0, if_ready}, 32'd0);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_imm_val", {7'd0, id_imm_val}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_if_ready", {31'd0, if_ready}, 32'd1);

      // single addi, one-cycle latency
      @(posedge clk);
      #1 id_ready = 1'b1;
      send(0);
      @(negedge clk);
      check("latency_id_valid", {31'd0, id_valid}, 32'd1);
      drain();

      // back-to-back stream with output always ready
      for (int i = 1; i < 13; i++) send(i);
      drain();

      // backpressure: A,B fill the buffer, C waits while id_ready low
      id_ready = 1'b0;
      send(0);
      send(1);
      @(negedge clk);
      check("full_if_ready", {31'd0, if_ready}, 32'd0);
      @(posedge clk);
      #1;
      fork
         send(2);
         begin
            repeat (3) begin
               @(negedge clk);
               check("stall_if_ready", {31'd0, if_ready}, 32'd0);
            end
            @(posedge clk);
            #1 id_ready = 1'b1;
         end
      join
      drain();

      // flush in TWO with an incoming packet
      id_ready = 1'b0;
      send(3);
      send(4);
      if_valid = 1'b1;
      if_instr = tbl[5].instr;
      if_pc    = pc_ctr;
      cur_idx  = 5;
      flush    = 1'b1;
      pc_ctr   = pc_ctr + 32'd4;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      if_valid = 1'b0;
      @(negedge clk);
      check("flush_id_valid", {31'd0, id_valid}, 32'd0);
      check("flush_if_ready", {31'd0, if_ready}, 32'd1);
      @(posedge clk);
      #1 id_ready = 1'b1;
      send(6);
      drain();

      // reset mid-stream
      id_ready = 1'b0;
      send(7);
      send(8);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("mid_rst_if_ready", {31'd0, if_ready}, 32'd0);
      check("mid_rst_id_pc", id_pc, 32'd0);
      check("mid_rst_rd", {27'd0, id_rd}, 32'd0);
      check("mid_rst_imm", {7'd0, id_imm_val}, 32'd0);
      check("mid_rst_ctrl", {26'd0, id_ctrl}, 32'd0);
      check("mid_rst_illegal", {31'd0, id_illegal}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("resume_if_ready", {31'd0, if_ready}, 32'd1);
      @(posedge clk);
      #1 id_ready = 1'b1;
      send(9);
      drain();

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
